// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package rgmii_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef logic [15:0] byte_cnt_t;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] data;
  } rx_beat_t;

  // rise/fall are {ctl, nibble} pairs from the DDR capture.
  function automatic rx_beat_t beat_from_ddr(input logic [4:0] rise, input logic [4:0] fall);
    rx_beat_t b;
    b.dv   = rise[4];
    b.er   = rise[4] ^ fall[4];
    b.data = {fall[3:0], rise[3:0]};
    return b;
  endfunction
endpackage

// File: rtl/iddr_wrapper.sv
// DDR input capture, same-edge-pipelined: Q1 (rising sample) and Q2 (falling
// sample) update together on the rising edge after the pair was sampled.
// SIMULATION selects a behavioural model; otherwise a per-bit fabric mapping.
module iddr_wrapper #(
  parameter int    WIDTH        = 5,
  parameter string DDR_CLK_EDGE = "SAME_EDGE_PIPELINED"
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q1_o,
  output logic [WIDTH-1:0] q2_o
);
  if (DDR_CLK_EDGE != "SAME_EDGE_PIPELINED") begin : g_bad_edge
    $error("iddr_wrapper: unsupported DDR_CLK_EDGE");
  end

`ifdef SIMULATION
  logic [WIDTH-1:0] rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rise_q <= '0;
    else          rise_q <= d_i;

  always_ff @(negedge clk_i or negedge rst_n_i)
    if (!rst_n_i) fall_q <= '0;
    else          fall_q <= d_i;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      q1_o <= '0;
      q2_o <= '0;
    end else begin
      q1_o <= rise_q;
      q2_o <= fall_q;
    end
`else
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic r_q, f_q, q1_q, q2_q;

    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        r_q  <= 1'b0;
        q1_q <= 1'b0;
        q2_q <= 1'b0;
      end else begin
        r_q  <= d_i[i];
        q1_q <= r_q;
        q2_q <= f_q;
      end

    always_ff @(negedge clk_i or negedge rst_n_i)
      if (!rst_n_i) f_q <= 1'b0;
      else          f_q <= d_i[i];

    assign q1_o[i] = q1_q;
    assign q2_o[i] = q2_q;
  end
`endif
endmodule

// File: rtl/rgmii_rx.sv
// RGMII receiver: DDR capture, preamble/SFD strip, frame delimiting with error flag.
// Define RGMII_RX_STATS_EN to add frame_count/error_count outputs.
module rgmii_rx
  import rgmii_pkg::*;
#(
  parameter int    MAX_FRAME_BYTES = 1522,
  parameter string DDR_CLK_EDGE    = "SAME_EDGE_PIPELINED"
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  rgmii_rxd,
  input  logic        rgmii_rx_ctl,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_user
`ifdef RGMII_RX_STATS_EN
  ,
  output logic [31:0] frame_count,
  output logic [31:0] error_count
`endif
);
  localparam byte_cnt_t MAX_CNT = byte_cnt_t'(MAX_FRAME_BYTES);

  logic [4:0] q1, q2;
  rx_beat_t   cap, hold_q;
  rx_state_e  state_q, state_d;
  byte_cnt_t  cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, last_q, last_d, user_q, user_d;

  iddr_wrapper #(.WIDTH(5), .DDR_CLK_EDGE(DDR_CLK_EDGE)) u_iddr (
    .clk_i  (clock),
    .rst_n_i(reset_n),
    .d_i    ({rgmii_rx_ctl, rgmii_rxd}),
    .q1_o   (q1),
    .q2_o   (q2)
  );

  assign cap = beat_from_ddr(q1, q2);

  // FSM acts on the hold stage; cap is one byte ahead and tells us whether dv ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    user_d  = 1'b0;
    unique case (state_q)
      IDLE: if (hold_q.dv) begin
        if (hold_q.data == PREAMBLE_BYTE) state_d = PREAMBLE;
        else if (hold_q.data == SFD_BYTE) begin
          state_d = DATA;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else state_d = DROP;
      end
      PREAMBLE: begin
        if (!hold_q.dv) state_d = IDLE;
        else if (hold_q.er) state_d = DROP;
        else if (hold_q.data == PREAMBLE_BYTE) state_d = PREAMBLE;
        else if (hold_q.data == SFD_BYTE) begin
          state_d = DATA;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else state_d = DROP;
      end
      DATA: begin
        if (!hold_q.dv) state_d = IDLE;
        else begin
          valid_d = 1'b1;
          data_d  = hold_q.data;
          err_d   = err_q | hold_q.er;
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
          if (!cap.dv) begin
            last_d  = 1'b1;
            user_d  = err_q | hold_q.er;
            state_d = IDLE;
          end else if (cnt_d == MAX_CNT) begin
            last_d  = 1'b1;
            user_d  = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: if (!hold_q.dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      hold_q  <= cap;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_user  = user_q;

`ifdef RGMII_RX_STATS_EN
  logic [31:0] frame_cnt_q, err_cnt_q;
  logic        drop_evt;

  assign drop_evt = (state_d == DROP) && (state_q == IDLE || state_q == PREAMBLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (valid_d && last_d && !user_d) frame_cnt_q <= frame_cnt_q + 32'd1;
      if ((valid_d && last_d && user_d) || drop_evt) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign error_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_rgmii_rx.sv
// Directed bench for rgmii_rx: a default instance plus a MAX_FRAME_BYTES=64 instance for overlength.
module tb_rgmii_rx;
  logic       clock, reset_n, ctl;
  logic [3:0] rxd;
  logic [7:0] m_data, m_data_b;
  logic       m_valid, m_last, m_user, m_valid_b, m_last_b, m_user_b;
`ifdef RGMII_RX_STATS_EN
  logic [31:0] fc_a, ec_a, fc_b, ec_b;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0, t_first = 0;
  int nv_a = 0, nl_a = 0, nu_a = 0, lpos_a = -1, upos_a = -1, viol_a = 0;
  int nv_b = 0, nl_b = 0, nu_b = 0, lpos_b = -1, upos_b = -1, viol_b = 0;
  int sb, sl, su, sb2, sl2, su2;
  logic [7:0] mbuf_a [1024];
  logic [7:0] mbuf_b [1024];
  int         cyc_a  [1024];

  rgmii_rx dut (
    .clock(clock), .reset_n(reset_n), .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_user(m_user)
`ifdef RGMII_RX_STATS_EN
    , .frame_count(fc_a), .error_count(ec_a)
`endif
  );

  rgmii_rx #(.MAX_FRAME_BYTES(64)) dut_ovl (
    .clock(clock), .reset_n(reset_n), .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_user(m_user_b)
`ifdef RGMII_RX_STATS_EN
    , .frame_count(fc_b), .error_count(ec_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (m_valid === 1'b1) begin
      mbuf_a[nv_a % 1024] = m_data;
      cyc_a[nv_a % 1024]  = cyc;
      if (m_last) begin nl_a++; lpos_a = nv_a; end
      if (m_user) begin nu_a++; upos_a = nv_a; end
      nv_a++;
    end else if (m_last !== 1'b0 || m_user !== 1'b0) viol_a++;
  end

  always @(negedge clock) begin
    if (m_valid_b === 1'b1) begin
      mbuf_b[nv_b % 1024] = m_data_b;
      if (m_last_b) begin nl_b++; lpos_b = nv_b; end
      if (m_user_b) begin nu_b++; upos_b = nv_b; end
      nv_b++;
    end else if (m_last_b !== 1'b0 || m_user_b !== 1'b0) viol_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // One byte per cycle: low nibble/dv before the rising edge, high nibble/dv^er before the falling edge.
  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    rxd = b[3:0];
    ctl = dv;
    @(posedge clock); #1;
    rxd = b[7:4];
    ctl = dv ^ er;
    @(negedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nbytes, input int er_at);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 1; i <= nbytes; i++) begin
      drive(8'(i), 1'b1, i == er_at);
      if (i == 1) t_first = cyc;
    end
  endtask

  task automatic snap();
    sb = nv_a; sl = nl_a; su = nu_a;
    sb2 = nv_b; sl2 = nl_b; su2 = nu_b;
  endtask

  task automatic chk_frame(input string tag, input int n, input int nuser);
    chk({tag, "_count"}, nv_a - sb, n);
    chk({tag, "_lasts"}, nl_a - sl, 1);
    chk({tag, "_lastpos"}, lpos_a - sb, n - 1);
    chk({tag, "_users"}, nu_a - su, nuser);
    for (int i = 0; i < n; i++) chk({tag, "_data"}, mbuf_a[(sb + i) % 1024], i + 1);
  endtask

  initial begin
    reset_n = 1'b0; rxd = '0; ctl = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_user", m_user, 0);
    chk("rst_data", m_data, 0);
`ifdef RGMII_RX_STATS_EN
    chk("rst_fc", fc_a, 0);
    chk("rst_ec", ec_a, 0);
`endif
    reset_n = 1'b1;
    idle(4);

    // Clean 64-byte frame
    snap();
    frame(64, 0); idle(6);
    chk_frame("t1", 64, 0);
    chk("t1_latency", cyc_a[sb % 1024] - t_first, 3);

    // er on byte 10
    snap();
    frame(64, 10); idle(6);
    chk_frame("t2", 64, 1);
    chk("t2_userpos", upos_a - sb, 63);
`ifdef RGMII_RX_STATS_EN
    chk("t2_ec", ec_a, 1);
    chk("t2_fc", fc_a, 1);
`endif

    // Corrupt preamble, then a good frame
    snap();
    drive(8'h55, 1, 0); drive(8'h55, 1, 0); drive(8'h57, 1, 0); drive(8'hD5, 1, 0);
    for (int i = 1; i <= 10; i++) drive(8'(i), 1'b1, 1'b0);
    idle(6);
    chk("t3_no_out", nv_a - sb, 0);
`ifdef RGMII_RX_STATS_EN
    chk("t3_ec", ec_a, 2);
`endif
    snap();
    frame(64, 0); idle(6);
    chk_frame("t3b", 64, 0);
`ifdef RGMII_RX_STATS_EN
    chk("t3_fc", fc_a, 2);
`endif

    // 100-byte frame: overlength on the 64-byte instance only
    snap();
`ifdef RGMII_RX_STATS_EN
    begin
      logic [31:0] ecb0, fcb0;
      ecb0 = ec_b; fcb0 = fc_b;
`endif
    frame(100, 0); idle(6);
    chk_frame("t4a", 100, 0);
    chk("t4b_count", nv_b - sb2, 64);
    chk("t4b_lasts", nl_b - sl2, 1);
    chk("t4b_lastpos", lpos_b - sb2, 63);
    chk("t4b_users", nu_b - su2, 1);
    chk("t4b_userpos", upos_b - sb2, 63);
    chk("t4b_lastdata", mbuf_b[(sb2 + 63) % 1024], 8'h40);
`ifdef RGMII_RX_STATS_EN
      chk("t4b_ec", ec_b - ecb0, 1);
      chk("t4b_fc", fc_b - fcb0, 0);
    end
`endif

    // Reset pulse at data byte 20
    snap();
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 1; i <= 19; i++) drive(8'(i), 1'b1, 1'b0);
    chk("t5_pre_valid", m_valid, 1);
    chk("t5_pre_data", m_data, 8'h10);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_data", m_data, 0);
    chk("t5_rst_last", m_last, 0);
    chk("t5_rst_user", m_user, 0);
    #1 reset_n = 1'b1;
    for (int i = 20; i <= 64; i++) drive(8'(i), 1'b1, 1'b0);
    idle(6);
    chk("t5_partial", nv_a - sb, 16);
    chk("t5_no_last", nl_a - sl, 0);
`ifdef RGMII_RX_STATS_EN
    chk("t5_ec", ec_a, 1);
    chk("t5_fc", fc_a, 0);
`endif
    snap();
    frame(64, 0); idle(6);
    chk_frame("t5b", 64, 0);

    // Back-to-back with a one-cycle gap
    snap();
    frame(64, 0); idle(1); frame(64, 0); idle(6);
    chk("t6_count", nv_a - sb, 128);
    chk("t6_lasts", nl_a - sl, 2);
    chk("t6_lastpos", lpos_a - sb, 127);
    chk("t6_data2", mbuf_a[(sb + 64) % 1024], 8'h01);
`ifdef RGMII_RX_STATS_EN
    chk("t6_fc", fc_a, 3);
`endif

    // dv drops right after SFD
    snap();
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    idle(6);
    chk("t7_no_out", nv_a - sb, 0);
    chk("t7_no_last", nl_a - sl, 0);

    chk("viol_a", viol_a, 0);
    chk("viol_b", viol_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
